// File: rtl/change_payout_ctrl.sv
// Coin change payout sequencer: greedy dispense (dollar..nickel) over a req/ack hopper handshake,
// with per-coin inventory tracking. Define PAYOUT_TIMEOUT_EN to add the hopper ack-timeout/jam handling.
module change_payout_ctrl #(
   parameter int unsigned INIT_QTY    = 20,
   parameter int unsigned REFILL_QTY  = 10,
   parameter int unsigned ACK_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [8:0] amount,
   output logic       busy,
   output logic       done,
   output logic [8:0] short_amt,
   output logic [5:0] coins_paid,
   output logic       coin_req,
   output logic [2:0] coin_sel,
   input  logic       coin_ack,
   input  logic       refill,
   input  logic [2:0] refill_sel,
   output logic [4:0] inv_empty,
   output logic       fault,
   output logic [1:0] dbg_state
);

   // Handshake: coin_req rises with coin_sel already stable, both hold until a cycle with
   // coin_ack=1 is sampled; coin_req then drops for at least one cycle before the next coin.
   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_REQ, S_DONE} state_t;

   state_t     state_q, state_d;
   logic [8:0] remaining_q, remaining_d;
   logic [8:0] short_q, short_d;
   logic [5:0] paid_q, paid_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] inv_q [5];
   logic [7:0] inv_d [5];
   logic       pick_found;
   logic [2:0] pick_sel;
   logic       ack_hit;
   logic       timeout_hit;

   function automatic logic [8:0] coin_value(input logic [2:0] code);
      case (code)
         3'd0:    coin_value = 9'd5;
         3'd1:    coin_value = 9'd10;
         3'd2:    coin_value = 9'd25;
         3'd3:    coin_value = 9'd50;
         default: coin_value = 9'd100;
      endcase
   endfunction

   assign ack_hit = (state_q == S_REQ) && coin_ack;

`ifdef PAYOUT_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;
   logic        fault_q;

   // Counter sits at zero outside REQ, so every REQ entry starts from zero.
   assign timeout_hit = (state_q == S_REQ) && !coin_ack && (tmo_cnt_q == 16'(ACK_TIMEOUT - 1));
   assign fault       = fault_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= 16'd0;
         fault_q   <= 1'b0;
      end else begin
         tmo_cnt_q <= (state_q == S_REQ) ? tmo_cnt_q + 16'd1 : 16'd0;
         fault_q   <= fault_q | timeout_hit;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign fault       = 1'b0;
`endif

   // Ascending scan: the last qualifying coin wins, which is the largest one.
   always_comb begin
      pick_found = 1'b0;
      pick_sel   = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (inv_q[i] != 8'd0 && coin_value(3'(i)) <= remaining_q) begin
            pick_found = 1'b1;
            pick_sel   = 3'(i);
         end
      end
   end

   always_comb begin
      logic [9:0] sum;
      sum = 10'd0;
      for (int i = 0; i < 5; i++) begin
         sum = {2'b00, inv_q[i]};
         if (refill && refill_sel == 3'(i)) sum = sum + 10'(REFILL_QTY);
         if (ack_hit && sel_q == 3'(i))     sum = sum - 10'd1;
         inv_d[i] = (sum > 10'd255) ? 8'hFF : sum[7:0];
         // A jammed hopper is taken out of service regardless of a concurrent refill.
         if (timeout_hit && sel_q == 3'(i)) inv_d[i] = 8'd0;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      short_d     = short_q;
      paid_d      = paid_q;
      sel_d       = sel_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               remaining_d = (amount > 9'd500) ? 9'd500 : amount;
               paid_d      = 6'd0;
               state_d     = S_SELECT;
            end
         end
         S_SELECT: begin
            if (pick_found) begin
               sel_d   = pick_sel;
               state_d = S_REQ;
            end else begin
               short_d = remaining_q;
               state_d = S_DONE;
            end
         end
         S_REQ: begin
            if (coin_ack) begin
               remaining_d = remaining_q - coin_value(sel_q);
               if (paid_q != 6'd63) paid_d = paid_q + 6'd1;
               state_d = S_SELECT;
            end else if (timeout_hit) begin
               state_d = S_SELECT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         remaining_q <= 9'd0;
         short_q     <= 9'd0;
         paid_q      <= 6'd0;
         sel_q       <= 3'd0;
         for (int i = 0; i < 5; i++) inv_q[i] <= 8'(INIT_QTY);
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         short_q     <= short_d;
         paid_q      <= paid_d;
         sel_q       <= sel_d;
         for (int i = 0; i < 5; i++) inv_q[i] <= inv_d[i];
      end
   end

   always_comb begin
      inv_empty = 5'd0;
      for (int i = 0; i < 5; i++) inv_empty[i] = (inv_q[i] == 8'd0);
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign coin_req   = (state_q == S_REQ);
   assign coin_sel   = sel_q;
   assign short_amt  = short_q;
   assign coins_paid = paid_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Self-checking bench for change_payout_ctrl: transaction-level greedy payout model compared every
// cycle, plus hand-computed payout sequences; timeout scenario runs when PAYOUT_TIMEOUT_EN is defined.
module tb_change_payout_ctrl;

   localparam int INIT    = 20;
   localparam int REFILL  = 10;
   localparam int ACK_TMO = 40;
   localparam int M_IDLE = 0, M_PICK = 1, M_REQ = 2, M_DONE = 3;

   logic       clk, rst_n, start, coin_ack, refill;
   logic [8:0] amount;
   logic [2:0] refill_sel;
   logic       busy, done, coin_req, fault;
   logic [8:0] short_amt;
   logic [5:0] coins_paid;
   logic [2:0] coin_sel;
   logic [4:0] inv_empty;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   // stimulus controls
   int ack_max     = 0;
   bit spur_en     = 0;
   bit rand_refill = 0;
   bit refill_on_ack = 0;
   bit hold_dollar = 0;
   int ack_wait    = 0;

   // observation log and expected sequence
   logic [2:0] sel_log[$];
   logic [2:0] exp_q[$];
   int  done_cnt = 0;
   bit  prev_req = 0;

   // behavioural model
   int coin_cents[5] = '{5, 10, 25, 50, 100};
   int m_inv[5];
   int m_mode, m_rem, m_paid, m_short, m_sel, m_cnt;
   bit m_fault;

   change_payout_ctrl #(.INIT_QTY(INIT), .REFILL_QTY(REFILL), .ACK_TIMEOUT(ACK_TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .amount(amount), .busy(busy), .done(done),
      .short_amt(short_amt), .coins_paid(coins_paid), .coin_req(coin_req), .coin_sel(coin_sel),
      .coin_ack(coin_ack), .refill(refill), .refill_sel(refill_sel), .inv_empty(inv_empty),
      .fault(fault), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int best_coin(input int rem);
      best_coin = -1;
      for (int c = 4; c >= 0; c--) begin
         if (best_coin < 0 && m_inv[c] > 0 && coin_cents[c] <= rem) best_coin = c;
      end
   endfunction

   // Model: advances once per clock using the inputs seen during the cycle that just ended.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_IDLE; m_rem = 0; m_paid = 0; m_short = 0; m_sel = 0; m_cnt = 0; m_fault = 0;
         for (int c = 0; c < 5; c++) m_inv[c] = INIT;
      end else begin : model_step
         int pick;
         bit disp, tmo;
         disp = (m_mode == M_REQ) && coin_ack;
         tmo  = 0;
`ifdef PAYOUT_TIMEOUT_EN
         if (m_mode == M_REQ && !coin_ack) begin
            m_cnt++;
            tmo = (m_cnt >= ACK_TMO);
         end
`endif
         pick = best_coin(m_rem);
         for (int c = 0; c < 5; c++) begin
            int v;
            v = m_inv[c];
            if (refill && int'(refill_sel) == c) v += REFILL;
            if (disp && m_sel == c) v -= 1;
            if (v > 255) v = 255;
            if (tmo && m_sel == c) v = 0;
            m_inv[c] = v;
         end
         case (m_mode)
            M_IDLE: if (start) begin
               m_rem  = (int'(amount) > 500) ? 500 : int'(amount);
               m_paid = 0;
               m_mode = M_PICK;
            end
            M_PICK: if (pick >= 0) begin
               m_sel = pick; m_cnt = 0; m_mode = M_REQ;
            end else begin
               m_short = m_rem; m_mode = M_DONE;
            end
            M_REQ: if (disp) begin
               m_rem -= coin_cents[m_sel];
               if (m_paid < 63) m_paid++;
               m_mode = M_PICK;
            end else if (tmo) begin
               m_fault = 1; m_mode = M_PICK;
            end
            default: m_mode = M_IDLE;
         endcase
      end
   end

   // Scoreboard compare, every cycle out of reset.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 0;
      end else begin
         chk("busy", busy, m_mode != M_IDLE);
         chk("done", done, m_mode == M_DONE);
         chk("coin_req", coin_req, m_mode == M_REQ);
         if (m_mode == M_REQ) chk("coin_sel", coin_sel, m_sel);
         chk("coins_paid", coins_paid, m_paid);
         if (m_mode == M_IDLE || m_mode == M_DONE) chk("short_amt", short_amt, m_short);
         for (int c = 0; c < 5; c++) chk($sformatf("inv_empty%0d", c), inv_empty[c], m_inv[c] == 0);
         chk("fault", fault, m_fault);
         if (coin_req && !prev_req) sel_log.push_back(coin_sel);
         prev_req = coin_req;
         if (done) done_cnt++;
      end
   end

   // Hopper / refill driver.
   always begin
      @(posedge clk);
      #1;
      refill = 1'b0;
      if (!rst_n) begin
         coin_ack = 1'b0;
      end else if (coin_req) begin
         if (hold_dollar && coin_sel == 3'd4) begin
            coin_ack = 1'b0;
         end else if (ack_wait == 0) begin
            coin_ack = 1'b1;
            if (refill_on_ack && coin_sel == 3'd2) begin
               refill = 1'b1; refill_sel = 3'd2;
            end
         end else begin
            coin_ack = 1'b0;
            ack_wait--;
         end
      end else begin
         coin_ack = spur_en && ($urandom_range(0, 5) == 0);
         ack_wait = $urandom_range(0, ack_max);
      end
      if (rand_refill && !refill && $urandom_range(0, 9) == 0) begin
         refill = 1'b1;
         refill_sel = 3'($urandom_range(0, 7));
      end
   end

   task automatic run_pay(input int amt, input bit mid, output int lat, output int sh, output int pd);
      sel_log.delete();
      done_cnt = 0;
      lat = -1; sh = -1; pd = -1;
      @(posedge clk); #1;
      start = 1'b1; amount = 9'(amt);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i; sh = int'(short_amt); pd = int'(coins_paid);
            break;
         end
         if (mid && i == 3) begin
            start = 1'b1; amount = 9'($urandom_range(0, 500));
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (lat < 0) chk("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt, 1);
   endtask

   task automatic chk_seq(input string name);
      chk({name, "_len"}, sel_log.size(), exp_q.size());
      foreach (exp_q[k]) if (k < sel_log.size()) chk(name, sel_log[k], exp_q[k]);
   endtask

   initial begin : main
      int lat, sh, pd;
      rst_n = 1'b0; start = 1'b0; amount = 9'd0; coin_ack = 1'b0; refill = 1'b0; refill_sel = 3'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_coin_req", coin_req, 0);
      chk("rst_coin_sel", coin_sel, 0);
      chk("rst_short", short_amt, 0);
      chk("rst_paid", coins_paid, 0);
      chk("rst_inv_empty", inv_empty, 0);
      chk("rst_fault", fault, 0);
      chk("rst_state", dbg_state, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 185 = 100+50+25+10, single-cycle ack
      run_pay(185, 0, lat, sh, pd);
      exp_q = '{3'd4, 3'd3, 3'd2, 3'd1};
      chk_seq("seq185");
      chk("paid185", pd, 4);
      chk("short185", sh, 0);
      chk("lat185", lat, 9);

      // 37 = 25+10, residue 2
      run_pay(37, 0, lat, sh, pd);
      exp_q = '{3'd2, 3'd1};
      chk_seq("seq37");
      chk("paid37", pd, 2);
      chk("short37", sh, 2);

      // amount 0: done two cycles after start
      run_pay(0, 0, lat, sh, pd);
      chk("lat0", lat, 1);
      chk("short0", sh, 0);
      chk("paid0", pd, 0);

      // drain the 19 remaining dollars
      run_pay(500, 0, lat, sh, pd);
      run_pay(500, 0, lat, sh, pd);
      run_pay(500, 0, lat, sh, pd);
      run_pay(500, 0, lat, sh, pd);
      exp_q = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3};
      chk_seq("seq_drain");
      chk("inv_empty_drain", inv_empty, 5'b10000);

      run_pay(200, 0, lat, sh, pd);
      exp_q = '{3'd3, 3'd3, 3'd3, 3'd3};
      chk_seq("seq200");
      chk("paid200", pd, 4);
      chk("short200", sh, 0);

      // 511 clamps to 500: ten fifties
      run_pay(511, 0, lat, sh, pd);
      chk("paid_clamp", pd, 10);
      chk("short_clamp", sh, 0);
      chk("inv_empty_clamp", inv_empty, 5'b10000);

      // start while busy is ignored; quarter refilled on its own ack cycle
      refill_on_ack = 1;
      run_pay(40, 1, lat, sh, pd);
      refill_on_ack = 0;
      exp_q = '{3'd2, 3'd1, 3'd0};
      chk_seq("seq40");
      chk("paid40", pd, 3);
      chk("short40", sh, 0);

      // randomized payouts against the model
      ack_max = 3; spur_en = 1; rand_refill = 1;
      for (int n = 0; n < 40; n++) begin
         run_pay($urandom_range(0, 511), $urandom_range(0, 1) == 1, lat, sh, pd);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      ack_max = 0; spur_en = 0; rand_refill = 0;
      repeat (3) @(negedge clk);

      // asynchronous reset while a coin is requested
      hold_dollar = 1;
      @(posedge clk); #1;
      start = 1'b1; amount = 9'd300;
      @(posedge clk); #1;
      start = 1'b0;
      begin : wait_req
         bit seen;
         seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (coin_req) begin seen = 1; break; end
         end
         chk("req_before_reset", seen, 1);
      end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_coin_req", coin_req, 0);
      chk("arst_busy", busy, 0);
      chk("arst_paid", coins_paid, 0);
      chk("arst_inv_empty", inv_empty, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef PAYOUT_TIMEOUT_EN
      // dollar hopper never acks: jammed after ACK_TMO cycles, fifties finish the job
      run_pay(100, 0, lat, sh, pd);
      exp_q = '{3'd4, 3'd3, 3'd3};
      chk_seq("seq_tmo");
      chk("fault_tmo", fault, 1);
      chk("paid_tmo", pd, 2);
      chk("short_tmo", sh, 0);
      chk("inv_empty_tmo", inv_empty, 5'b10000);
`endif
      hold_dollar = 0;

      run_pay(65, 0, lat, sh, pd);
      exp_q = '{3'd3, 3'd1, 3'd0};
      chk_seq("seq65");
      chk("short65", sh, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/change_payout_ctrl.md
Name: change_payout_ctrl

Overview:
- Sequences coin change payout after a vend or cancel.
- Accepts a change amount in cents and dispenses it greedily, largest coin first (dollar, fifty, quarter, dime, nickel), through a req/ack handshake to a coin hopper.
- Tracks per-coin hopper inventory and reports any unpayable remainder.
- Sits between the vend/credit logic (source of the change value) and the hopper drivers.

Parameters:
- INIT_QTY, 20: reset inventory count for every coin type (0..255).
- REFILL_QTY, 10: coins added to one inventory per refill pulse.
- ACK_TIMEOUT, 1000: cycles to wait for coin_ack; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to pay `amount`; accepted only when busy=0.
- amount  input  9  change in cents, 0..500.
- busy  output  1  payout in progress.
- done  output  1  one-cycle pulse at end of payout.
- short_amt  output  9  unpaid remainder in cents; valid with done, held until next start.
- coins_paid  output  6  coins dispensed in the current/last payout.
- coin_req  output  1  hopper dispense request.
- coin_sel  output  3  coin code: 0 nickel, 1 dime, 2 quarter, 3 fifty, 4 dollar.
- coin_ack  input  1  hopper completion, sampled while coin_req=1.
- refill  input  1  one-cycle refill pulse.
- refill_sel  input  3  coin code to refill; codes 5-7 are ignored.
- inv_empty  output  5  bit n=1 when inventory of coin code n is 0.
- fault  output  1  sticky hopper-timeout flag; cleared by reset only.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, coin_req=0, coin_sel=0, short_amt=0, coins_paid=0, fault=0.
  - All five 8-bit inventories = INIT_QTY; inv_empty derived from them.
  - Reset mid-payout aborts immediately; coin_req drops asynchronously and no partial accounting is kept.
- States: IDLE, SELECT, REQ, DONE.
- IDLE:
  - start=1 latches `amount` into a 9-bit `remaining`, clears coins_paid, goes to SELECT.
  - busy=1 from the next cycle.
  - amount>500 is clamped to 500.
- SELECT (one cycle, coin_req=0):
  - Pick the largest coin with value <= remaining and inventory > 0.
  - If one is found: drive coin_sel, go to REQ.
  - If remaining==0 or no coin qualifies: go to DONE.
- REQ:
  - coin_req=1 with coin_sel held stable until coin_ack=1.
  - On ack: inventory[sel] -= 1, remaining -= value, coins_paid += 1, coin_req=0 next cycle, back to SELECT.
  - coin_req is therefore low for at least one cycle between coins.
  - coin_ack outside REQ is ignored.
- DONE: done=1 for one cycle, short_amt=remaining, busy=0, then IDLE.
- start while busy=1: ignored, with no queueing.
- amount=0: IDLE -> SELECT -> DONE; done pulses 2 cycles after start, short_amt=0.
- Non-multiple-of-5 amounts: the sub-5 residue ends in short_amt.
- Latency per coin: SELECT(1) + REQ(>=1) cycles.
- Refill:
  - Adds REFILL_QTY to inventory[refill_sel], saturating at 255.
  - Accepted in any state.
  - Refill and dispense on the same coin in the same cycle: net change = +REFILL_QTY-1, saturating.
  - A refill landing during SELECT is visible from the next SELECT.
- coins_paid saturates at 63.

Optional Feature:
- Macro: PAYOUT_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs while in REQ and clears on entry to REQ.
  - Reaching ACK_TIMEOUT without ack: drop coin_req, force inventory[sel]=0 (treat hopper as jammed), set fault=1, return to SELECT. Payout continues with smaller coins; remaining is unchanged.
- Not defined: REQ waits indefinitely for ack; fault is tied to 0 and no counter is built.

Test Plan:
- Reset, then start amount=185 with ack 1 cycle after each req: coin_sel sequence 4,3,2,1; coins_paid=4; short_amt=0; done pulses once.
- Refill dollar inventory to 0 first (INIT_QTY=0 build or drain), then amount=200: four fifties paid; inv_empty[4]=1; short_amt=0.
- amount=37 with INIT_QTY=20: sel 2,1 paid (35); short_amt=2; coins_paid=2.
- Nickel-only inventory 1, all others 0, amount=15: one nickel paid; short_amt=10; done.
- Second start pulse mid-payout and refill of same coin on its ack cycle: start ignored; inventory = old+REFILL_QTY-1.
- rst_n low while coin_req=1: coin_req=0 immediately; inventories=INIT_QTY; with PAYOUT_TIMEOUT_EN and ack withheld: fault=1 after ACK_TIMEOUT cycles and the next smaller coin is requested.
